// File: rtl/sigma_delta_pkg.sv
// Shared sigma-delta constants and helpers: element count, thermometer
// fill and modulo rotation over the unit-element array.
package sigma_delta_pkg;

  localparam int unsigned DEFAULT_CODE_W = 4;
  localparam int unsigned MAX_CODE_W     = 6;
  localparam int unsigned MAX_ELEM       = 63;
  localparam int unsigned MAX_AMT_W      = 7;

  // Number of unit elements addressed by a code_w-bit quantiser code.
  function automatic int unsigned elem_count(input int unsigned code_w);
    return (32'd1 << code_w) - 32'd1;
  endfunction

  // Bits 0..code-1 set, limited to the low 'width' bits.
  function automatic logic [MAX_ELEM-1:0] thermo(input logic [MAX_CODE_W-1:0] code,
                                                 input int unsigned           width);
    logic [MAX_ELEM-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < MAX_ELEM; i++) begin
      t[i[5:0]] = (i < width) && (i < 32'(code));
    end
    return t;
  endfunction

  // Rotate the low 'modulus' bits of vec left by amount; bit modulus-1 wraps to bit 0.
  // amount is assumed < modulus, so one conditional subtract folds the index.
  function automatic logic [MAX_ELEM-1:0] rot_mod(input logic [MAX_ELEM-1:0]  vec,
                                                  input logic [MAX_AMT_W-1:0] amount,
                                                  input logic [MAX_AMT_W-1:0] modulus);
    logic [MAX_ELEM-1:0] r;
    int unsigned         j;
    r = '0;
    for (int unsigned i = 0; i < MAX_ELEM; i++) begin
      j = i + 32'(amount);
      if (j >= 32'(modulus)) j = j - 32'(modulus);
      if (i < 32'(modulus)) r[j[5:0]] = vec[i[5:0]];
    end
    return r;
  endfunction

endpackage

// File: rtl/dwa_thermo_decoder_if.sv
// Quantiser-to-DAC element bus: sample strobe/code in, element enables out.
interface dwa_thermo_decoder_if
  import sigma_delta_pkg::*;
#(
  parameter int unsigned CODE_W = DEFAULT_CODE_W
);
  localparam int unsigned ELEM = elem_count(CODE_W);

  logic              en;
  logic [CODE_W-1:0] code;
  logic              ptr_clr;
  logic [ELEM-1:0]   elem;
  logic [CODE_W-1:0] ptr;
  logic              valid_o;

  modport master (output en, code, ptr_clr, input  elem, ptr, valid_o);
  modport slave  (input  en, code, ptr_clr, output elem, ptr, valid_o);

endinterface

// File: rtl/dwa_thermo_decoder_thermo_enc.sv
// Combinational binary-to-thermometer encoder, CODE_W-bit code to ELEM enables.
module thermo_enc
  import sigma_delta_pkg::*;
#(
  parameter int unsigned CODE_W = DEFAULT_CODE_W
) (
  input  logic [CODE_W-1:0]               code,
  output logic [elem_count(CODE_W)-1:0]   therm_c
);
  localparam int unsigned ELEM = elem_count(CODE_W);

  assign therm_c = ELEM'(thermo(MAX_CODE_W'(code), ELEM));

endmodule

// File: rtl/dwa_thermo_decoder.sv
// Registered thermometer decoder with data-weighted-averaging element rotation.
// Rotation is built only when DWA_EN is defined; otherwise elements fill from bit 0.
module dwa_thermo_decoder
  import sigma_delta_pkg::*;
#(
  parameter int unsigned CODE_W = DEFAULT_CODE_W
) (
  input logic                 clk,
  input logic                 rst,
  dwa_thermo_decoder_if.slave bus
);
  localparam int unsigned ELEM = elem_count(CODE_W);

  logic [ELEM-1:0]   therm_c;
  logic [ELEM-1:0]   elem_nxt_c;
  logic [ELEM-1:0]   elem_q;
  logic              valid_q;

  thermo_enc #(.CODE_W(CODE_W)) u_thermo_enc (
    .code    (bus.code),
    .therm_c (therm_c)
  );

`ifdef DWA_EN
  logic [CODE_W-1:0] ptr_q;
  logic [CODE_W-1:0] p_c;
  logic [CODE_W:0]   sum_c;
  logic [CODE_W-1:0] ptr_nxt_c;

  // Effective pointer, modulo-ELEM advance and rotated enables.
  always_comb begin
    p_c        = bus.ptr_clr ? '0 : ptr_q;
    sum_c      = {1'b0, p_c} + {1'b0, bus.code};
    ptr_nxt_c  = sum_c[CODE_W-1:0];
    if (sum_c >= (CODE_W+1)'(ELEM)) begin
      ptr_nxt_c = CODE_W'(sum_c - (CODE_W+1)'(ELEM));
    end
    elem_nxt_c = ELEM'(rot_mod(MAX_ELEM'(therm_c), MAX_AMT_W'(p_c), MAX_AMT_W'(ELEM)));
  end

  // Pointer advances per sample; a clear without a sample just zeroes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (bus.en) begin
      ptr_q <= ptr_nxt_c;
    end else if (bus.ptr_clr) begin
      ptr_q <= '0;
    end
  end

  assign bus.ptr = ptr_q;
`else
  logic unused_ptr_clr;

  assign unused_ptr_clr = bus.ptr_clr;
  assign elem_nxt_c     = therm_c;
  assign bus.ptr        = '0;
`endif

  // Output and valid flops; elem holds between samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      elem_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.en;
      if (bus.en) begin
        elem_q <= elem_nxt_c;
      end
    end
  end

  assign bus.elem    = elem_q;
  assign bus.valid_o = valid_q;

endmodule

// File: tb/tb_dwa_thermo_decoder.sv
// Self-checking bench for dwa_thermo_decoder (CODE_W=4) against an index-level model.
module tb_dwa_thermo_decoder;

  localparam int CODE_W = 4;
  localparam int ELEM   = 15;

  logic clk;
  logic rst;

  dwa_thermo_decoder_if #(.CODE_W(CODE_W)) bus ();

  dwa_thermo_decoder #(.CODE_W(CODE_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: pointer as plain integer, enables built element by element.
  int             m_ptr   = 0;
  logic [63:0]    m_elem  = '0;
  logic           m_valid = 1'b0;
  int             use_cnt [ELEM];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_edge(input bit e, input int c, input bit clr);
    int p;
`ifdef DWA_EN
    p = clr ? 0 : m_ptr;
`else
    p = 0;
`endif
    if (e) begin
      m_elem = '0;
      for (int i = 0; i < c; i++) m_elem[(p + i) % ELEM] = 1'b1;
`ifdef DWA_EN
      m_ptr = (p + c) % ELEM;
`endif
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
`ifdef DWA_EN
      if (clr) m_ptr = 0;
`endif
    end
  endtask

  // Drive one sample, let one edge pass, compare every output with the model.
  task automatic step(input bit e, input int c, input bit clr);
    bus.en      = e;
    bus.code    = CODE_W'(c);
    bus.ptr_clr = clr;
    @(posedge clk);
    #1;
    model_edge(e, c, clr);
    check("elem",  64'(bus.elem),    m_elem);
    check("ptr",   64'(bus.ptr),     64'(m_ptr));
    check("valid", 64'(bus.valid_o), 64'(m_valid));
  endtask

  task automatic expect_out(input string tag, input int e_elem, input int e_ptr);
    check({tag, "_elem"}, 64'(bus.elem), 64'(e_elem));
    check({tag, "_ptr"},  64'(bus.ptr),  64'(e_ptr));
  endtask

  initial begin
    int mn;
    int mx;
    rst         = 1'b1;
    bus.en      = 1'b0;
    bus.code    = '0;
    bus.ptr_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_elem",  64'(bus.elem),    64'h0);
    check("rst_ptr",   64'(bus.ptr),     64'h0);
    check("rst_valid", 64'(bus.valid_o), 64'h0);
    rst = 1'b0;

    // Basic sequence
    step(1, 3, 0);
`ifdef DWA_EN
    expect_out("seq3", 'h0007, 3);
    step(1, 5, 0);
    expect_out("seq5", 'h00F8, 8);
    // Wrap: reach ptr=13 then apply code 4
    step(1, 5, 0);
    expect_out("to13", 'h1F00, 13);
    step(1, 4, 0);
    expect_out("wrap", 'h6003, 2);
    // Extremes at ptr=6
    step(1, 6, 1);
    expect_out("clr6", 'h003F, 6);
    step(1, 15, 0);
    expect_out("full", 'h7FFF, 6);
    step(1, 0, 0);
    expect_out("zero", 'h0000, 6);
    step(1, 3, 0);
    expect_out("to9", 'h01C0, 9);
    step(1, 2, 1);
    expect_out("clr_en", 'h0003, 2);
`else
    expect_out("seq3", 'h0007, 0);
    step(1, 5, 0);
    expect_out("seq5", 'h001F, 0);
    step(1, 5, 1);
    expect_out("code5b", 'h001F, 0);
    step(1, 15, 0);
    expect_out("full", 'h7FFF, 0);
    step(1, 0, 0);
    expect_out("zero", 'h0000, 0);
    step(1, 2, 1);
    expect_out("two", 'h0003, 0);
`endif
    // Hold for 3 cycles, then a clear without a sample
    step(1, 7, 0);
    repeat (3) step(0, $urandom_range(0, 15), 0);
    step(0, 9, 1);

    // Async reset mid-cycle, held across an edge with a pending sample
    step(1, 11, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_elem",  64'(bus.elem),    64'h0);
    check("arst_ptr",   64'(bus.ptr),     64'h0);
    check("arst_valid", 64'(bus.valid_o), 64'h0);
    bus.en   = 1'b1;
    bus.code = CODE_W'(5);
    @(posedge clk);
    #1;
    check("arst_hold_elem", 64'(bus.elem), 64'h0);
    rst     = 1'b0;
    m_ptr   = 0;
    m_elem  = '0;
    m_valid = 1'b0;

    // Random mix including clears and idle cycles
    for (int n = 0; n < 2000; n++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 15) == 0);
    end

    // Soak: start from pointer 0, count per-element usage from DUT outputs
    step(0, 0, 1);
    for (int k = 0; k < ELEM; k++) use_cnt[k] = 0;
    for (int n = 0; n < 10000; n++) begin
      step($urandom_range(0, 7) != 0, $urandom_range(0, 15), 0);
      if (bus.valid_o) begin
        for (int k = 0; k < ELEM; k++) if (bus.elem[k]) use_cnt[k]++;
      end
    end
    mn = use_cnt[0];
    mx = use_cnt[0];
    for (int k = 1; k < ELEM; k++) begin
      if (use_cnt[k] < mn) mn = use_cnt[k];
      if (use_cnt[k] > mx) mx = use_cnt[k];
    end
`ifdef DWA_EN
    check("balance", 64'((mx - mn) <= 1), 64'h1);
`endif
    check("used_some", 64'(mx > 0), 64'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dwa_thermo_decoder.md
# dwa_thermo_decoder

Parametrised, registered binary-to-thermometer decoder for the sigma-delta DAC unit-element array, with data-weighted-averaging (DWA) element rotation. It takes the N-bit quantiser code each modulator sample and drives 2^N−1 unit-element enables. A rotating pointer spreads element usage so that element mismatch error is first-order noise-shaped. It sits between the modulator quantiser and the unit-element DAC drivers.

## Interface
- CODE_W, 4, quantiser code width in bits; legal range 2..6
- ELEM (localparam), 2^CODE_W−1, number of unit elements
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  sample strobe; code is consumed on the clk edge when en=1
- code  in  CODE_W  unsigned element count to turn on, 0..ELEM
- ptr_clr  in  1  synchronous pointer clear
- elem  out  ELEM  unit-element enables; bit k drives element k
- ptr  out  CODE_W  current rotation pointer, 0..ELEM−1; debug/observability
- valid_o  out  1  high for one cycle when elem holds a newly decoded sample

## Operation
- Reset (async, rst=1): elem=0, ptr=0, valid_o=0, taking effect immediately and independently of clk. Reset asserted mid-stream discards the in-flight sample.
- The effective pointer is p = 0 when ptr_clr=1, otherwise p = ptr.
- On a clk edge with en=1:
  - t = thermometer(code), i.e. bits 0..code−1 set.
  - elem ← t rotated left by p, modulo ELEM (bit ELEM−1 wraps to bit 0; this is not modulo 2^CODE_W).
  - Equivalently, element (p+i) mod ELEM is set for i = 0..code−1.
  - ptr ← (p + code) mod ELEM.
  - valid_o ← 1.
- Pointer arithmetic: compute s = p + code at CODE_W+1 bits; if s ≥ ELEM then ptr ← s − ELEM, else ptr ← s. A single subtraction always suffices.
- On a clk edge with en=0: elem holds its value and valid_o ← 0.
  - If ptr_clr=1, ptr ← 0.
  - Otherwise ptr holds.
- Boundaries:
  - code=0: elem ← 0 and ptr is unchanged.
  - code=ELEM: elem ← all ones and ptr is unchanged.
  - Wrap-around: if p + code crosses ELEM, the set bits straddle bit ELEM−1 and bit 0.
- ptr_clr and en asserted together: the sample is decoded from pointer 0, and ptr ← code mod ELEM.
- No state machine is needed beyond the pointer register; the pointer is the sole architectural state besides the output registers.

## Timing
- Latency: exactly 1 cycle from the en/code edge to elem and valid_o.
- Full throughput: en may be asserted every cycle.
- elem, ptr and valid_o are driven directly from flops, with no combinational path from any input to any output.
- code and ptr_clr are sampled only on the clk edge; they need not be held stable between edges.
- Critical path is p → add → compare/subtract → rotate mux. At CODE_W=6 this is a 63-way barrel rotate; it is acceptable as a single stage.

## Configuration
- DWA_EN defined: rotation as described above; ptr advances per sample.
- DWA_EN undefined:
  - elem ← thermometer(code) with no rotation, so bits 0..code−1 are always the ones used.
  - ptr is tied to 0 and ptr_clr is ignored.
  - Latency, valid_o and reset behaviour are identical to the DWA_EN build.

## Structure
- Shared package sigma_delta_pkg holds:
  - function elem_count(code_w) returning 2^code_w−1
  - function thermo(code, width)
  - function rot_mod(vec, amount, modulus)
  - default CODE_W constant shared with the modulator
- One combinational sub-module, thermo_enc (CODE_W → ELEM), converts code to thermometer. It is reused by the unrotated path and by any future segmented decoder.
- The top level holds the pointer register, the modulo adder, the rotator and the output/valid flops.

## Test plan
All scenarios use CODE_W=4 (ELEM=15) and DWA_EN defined unless stated otherwise.
- Reset: assert rst asynchronously mid-cycle → elem=0x0000, ptr=0 and valid_o=0 before the next edge.
- Sequence: code=3 then code=5 with en=1 → elem=0x0007, ptr=3; then elem=0x00F8, ptr=8; valid_o high on both cycles.
- Wrap: with ptr=13, apply code=4 → elem=0x6003 (bits 13, 14, 0, 1), ptr=2.
- Extremes: code=15 at ptr=6 → elem=0x7FFF, ptr=6; code=0 → elem=0x0000, ptr=6.
- Hold and clear:
  - en=0 for 3 cycles → elem and ptr unchanged, valid_o=0.
  - ptr_clr=1 with en=1 and code=2 at ptr=9 → elem=0x0003, ptr=2.
- DWA_EN undefined: code=5 at any history → elem=0x001F and ptr=0 every sample.
- Random soak: over 10k random codes, each element's on-count differs from every other element's on-count by at most 1.
